// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//   Shares one register-file access port between two masters (M0, M1).
//   Contention is resolved round-robin. Each transaction issues exactly one
//   single-cycle WrEN or RdEN strobe. Reads wait for RdData_valid, bounded
//   by a timeout. Each master gets a one-cycle ack, read data and an error
//   flag.
//
//   Handshake (both masters): a master raises Mx_req with Mx_wr/Mx_addr/
//   Mx_wdata stable and holds them until it samples Mx_ack high. Mx_ack is a
//   single-cycle completion pulse. Mx_rdata and Mx_err are meaningful while
//   Mx_ack is high, and Mx_rdata holds until that master's next read.
//
// Ports
//   CLK, RST            clock; synchronous active-low reset
//   Mx_req/wr/addr/wdata  per-master request fields (x = 0, 1)
//   Mx_ack/rdata/err      per-master completion, read data, timeout flag
//   WrEN, RdEN          register-file strobes (one-cycle pulses)
//   Address, WrData     register-file address / write data (held between uses)
//   Rd_data, RdData_valid  register-file read return
//   busy                high whenever the FSM is not in IDLE
//   state_dbg           current FSM state (IDLE=0, WRITE=1, READ_WAIT=2, DONE=3)
module reg_file_arbiter #(
  parameter int Data_width    = 8,
  parameter int Address_width = 4,
  parameter int Timeout       = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     M0_req,
  input  logic                     M0_wr,
  input  logic [Address_width-1:0] M0_addr,
  input  logic [Data_width-1:0]    M0_wdata,
  output logic                     M0_ack,
  output logic [Data_width-1:0]    M0_rdata,
  output logic                     M0_err,
  input  logic                     M1_req,
  input  logic                     M1_wr,
  input  logic [Address_width-1:0] M1_addr,
  input  logic [Data_width-1:0]    M1_wdata,
  output logic                     M1_ack,
  output logic [Data_width-1:0]    M1_rdata,
  output logic                     M1_err,
  output logic                     WrEN,
  output logic                     RdEN,
  output logic [Address_width-1:0] Address,
  output logic [Data_width-1:0]    WrData,
  input  logic [Data_width-1:0]    Rd_data,
  input  logic                     RdData_valid,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  localparam int CntW = $clog2(Timeout) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     owner_q, owner_d;   // 0 = M0, 1 = M1
  logic                     last_q, last_d;     // most recent owner
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic [Address_width-1:0] addr_q, addr_d;
  logic [Data_width-1:0]    wdata_q, wdata_d;
  logic                     ack0_q, ack0_d, ack1_q, ack1_d;
  logic                     err0_q, err0_d, err1_q, err1_d;
  logic [Data_width-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                     busy_q, busy_d;

  logic any_req;
  logic grant_m1;
  logic grant_wr;
  logic rd_timeout;

  // On a tie the master that did not win last time is granted.
  assign any_req    = M0_req | M1_req;
  assign grant_m1   = M1_req & (~M0_req | ~last_q);
  assign grant_wr   = grant_m1 ? M1_wr : M0_wr;
  assign rd_timeout = (cnt_q == CntLast);

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (any_req) state_d = grant_wr ? WRITE : READ_WAIT;
      WRITE:     state_d = DONE;
      READ_WAIT: if (RdData_valid || rd_timeout) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered-output logic. Strobes, acks and errors default low so each
  // is a single-cycle pulse; data outputs default to holding.
  always_comb begin
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant_m1;
          last_d  = grant_m1;
          addr_d  = grant_m1 ? M1_addr  : M0_addr;
          wdata_d = grant_m1 ? M1_wdata : M0_wdata;
          if (grant_wr) begin
            wr_en_d = 1'b1;
          end else begin
            rd_en_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      WRITE: begin
        if (owner_q) ack1_d = 1'b1;
        else         ack0_d = 1'b1;
      end
      READ_WAIT: begin
        // Valid data on the final wait cycle takes priority over the timeout.
        if (RdData_valid) begin
          if (owner_q) begin
            rdata1_d = Rd_data;
            ack1_d   = 1'b1;
          end else begin
            rdata0_d = Rd_data;
            ack0_d   = 1'b1;
          end
        end else if (rd_timeout) begin
          if (owner_q) begin
            rdata1_d = '0;
            ack1_d   = 1'b1;
            err1_d   = 1'b1;
          end else begin
            rdata0_d = '0;
            ack0_d   = 1'b1;
            err0_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  assign WrEN      = wr_en_q;
  assign RdEN      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign M0_ack    = ack0_q;
  assign M1_ack    = ack1_q;
  assign M0_err    = err0_q;
  assign M1_err    = err1_q;
  assign M0_rdata  = rdata0_q;
  assign M1_rdata  = rdata1_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Two-master arbiter and access sequencer for the register file, so the UART command controller (M0) and a second on-chip requester (M1, e.g. a status/debug scanner) can share the single `WrEN`/`RdEN`/`Address`/`WrData` port. It resolves contention round-robin, issues exactly one single-cycle register-file strobe per transaction, and waits for `RdData_valid` on reads with a bounded timeout. It returns a per-master acknowledge, read data and error flag.

## Interface
- `Data_width`, 8: register-file data width.
- `Address_width`, 4: register-file address width.
- `Timeout`, 15: maximum number of cycles spent in READ_WAIT before a read is aborted; must be ≥ 1.

Ports (x = 0, 1):
- `CLK`  in  1  single clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-low.
- `Mx_req`  in  1  request; held high with fields stable until `Mx_ack`.
- `Mx_wr`  in  1  1 = write, 0 = read.
- `Mx_addr`  in  Address_width  target address.
- `Mx_wdata`  in  Data_width  write data.
- `Mx_ack`  out  1  one-cycle completion pulse.
- `Mx_rdata`  out  Data_width  read result; valid while `Mx_ack` is high, held until the next read by that master.
- `Mx_err`  out  1  read timeout; valid only with `Mx_ack`.
- `WrEN`, `RdEN`  out  1  register-file strobes; each is a one-cycle pulse.
- `Address`  out  Address_width  register-file address.
- `WrData`  out  Data_width  register-file write data.
- `Rd_data`  in  Data_width  register-file read data.
- `RdData_valid`  in  1  read data valid.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- All outputs are registered. On reset all outputs are 0, state = IDLE, the read-timeout counter = 0, and `last` = 1, so M0 wins the first tie.
- The FSM has four states: IDLE, WRITE, READ_WAIT and DONE.
- IDLE:
  - If no request is present, remain in IDLE.
  - If only one `Mx_req` is high, grant that master.
  - If both are high, grant master `~last`.
  - On a grant, at the same edge:
    - latch the owner and set `last` to the owner;
    - load `Address` with `Mx_addr` and `WrData` with `Mx_wdata`;
    - for a write: `WrEN` <= 1, next state WRITE;
    - for a read: `RdEN` <= 1, clear the counter, next state READ_WAIT.
- WRITE: `WrEN` <= 0, owner's ack <= 1, `err` <= 0, then go to DONE.
- READ_WAIT:
  - `RdEN` <= 0 at the first edge in this state.
  - If `RdData_valid` is sampled high: owner's `rdata` <= `Rd_data`, `ack` <= 1, `err` <= 0, then go to DONE.
  - Otherwise, if counter == Timeout−1: `rdata` <= 0, `ack` <= 1, `err` <= 1, then go to DONE.
  - Otherwise, increment the counter.
  - If `RdData_valid` arrives on the final timeout cycle, the valid data wins and no error is flagged.
- DONE:
  - The ack pulse is visible in this cycle.
  - At the next edge: ack and err <= 0, next state IDLE.
  - Requests sampled during DONE are ignored. The requester drops `req` on the edge where it samples `ack`.
- `RdData_valid` is ignored outside READ_WAIT.
- The non-owning master's outputs never change during another master's transaction.
- `Address` and `WrData` hold their last value between transactions.
- Reset mid-transaction: the in-flight access is abandoned with no ack, and all outputs and state return to their reset values at the sampling edge.

## Timing
- Request sampled at edge E0:
  - strobe (`WrEN` or `RdEN`) is high for cycle E0→E1;
  - write ack is high for E1→E2.
- Read with `RdData_valid` first sampled at edge En: ack is high En→En+1. With a register file that returns valid one cycle after `RdEN`, ack is high E2→E3.
- A read with no valid times out at E0+Timeout; ack + err are high for the following cycle.
- Back-to-back: the next grant occurs no earlier than the edge ending IDLE, giving a minimum of 3 cycles per write.
- Fairness: with both masters continuously requesting, grants alternate M0, M1, M0, …

## Test plan
- Reset, then M0 writes 0xA5 to address 3 → `WrEN` high for exactly 1 cycle with `Address`=3, `WrData`=0xA5; `M0_ack` 1 cycle later; `M0_err`=0; `M1_ack` never asserts.
- M1 reads address 2, and the register-file model returns 0x3C one cycle after `RdEN` → `RdEN` 1 cycle; `M1_ack` with `M1_rdata`=0x3C, `M1_err`=0, ack at E2→E3.
- Both requesting continuously with writes (M0 → addr 0, M1 → addr 1) for 6 transactions → `Address` sequence 0, 1, 0, 1, 0, 1; each transaction takes 3 cycles; `busy` is low for exactly one cycle between transactions.
- M0 read with `RdData_valid` never asserted, Timeout=15 → `M0_ack`=1, `M0_err`=1, `M0_rdata`=0 at cycle E0+15. Repeat with valid arriving on the 15th wait cycle → `err`=0 and the data is captured.
- `RST` low for one edge during READ_WAIT → all outputs 0 and `busy`=0 afterwards, no ack. A subsequent tie grants M0 first.
- Spurious `RdData_valid` pulses during IDLE and WRITE → no ack and no `rdata` change.
